// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan controller and its host.
// The slave side is the controller; the master side drives the scan requests.
interface decoder_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         line_en;
  logic               A1;
  logic               A0;
  logic               active;
  logic               busy;
  logic               step;
  logic               done;

  modport master (
    output start, stop, cont, dwell, line_en,
    input  A1, A0, active, busy, step, done
  );

  modport slave (
    input  start, stop, cont, dwell, line_en,
    output A1, A0, active, busy, step, done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sequential select source for a 2-to-4 decoder: visits each enabled line for a
// programmable dwell, either once or continuously. All outputs come straight from flops.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  decoder_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [1:0]         addr_q, addr_d;
  logic               active_q, active_d;
  logic               busy_q, busy_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] reload_q, reload_d;
  logic [3:0]         mask_q, mask_d;
  logic               cont_q, cont_d;

  function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
    logic [1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Bit 2 flags that an enabled line exists above cur; bits 1:0 give its index.
  function automatic logic [2:0] next_idx(input logic [3:0] mask, input logic [1:0] cur);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  logic [2:0] nxt;
  assign nxt = next_idx(mask_q, addr_q);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    active_d = active_q;
    busy_d   = busy_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mask_d   = mask_q;
    cont_d   = cont_q;

    case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop && (bus.line_en != 4'b0000)) begin
          mask_d   = bus.line_en;
          cont_d   = bus.cont;
          // A dwell of zero behaves as one cycle per line.
          reload_d = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
          cnt_d    = reload_d;
          addr_d   = lowest_idx(bus.line_en);
          active_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = StScan;
        end
      end
      StScan: begin
        if (bus.stop) begin
          state_d  = StIdle;
          active_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxt[2]) begin
          addr_d = nxt[1:0];
          cnt_d  = reload_q;
          step_d = 1'b1;
        end else if (cont_q) begin
          addr_d = lowest_idx(mask_q);
          cnt_d  = reload_q;
          step_d = 1'b1;
        end else begin
          state_d  = StDone;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d  = StIdle;
        active_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      reload_q <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      step_q   <= step_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
    end
  end

  assign bus.A1     = addr_q[1];
  assign bus.A0     = addr_q[0];
  assign bus.active = active_q;
  assign bus.busy   = busy_q;
  assign bus.step   = step_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: directed and randomized scans checked against an
// arithmetic reference of the expected per-cycle line sequence.
module tb_decoder_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_scan_ctrl_if #(.DWELL_W(8)) bus ();

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] last_addr = 2'd0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] a, input logic act,
                            input logic bsy, input logic stp, input logic dn);
    check_eq({tag, ".addr"},   {6'b0, bus.A1, bus.A0}, {6'b0, a});
    check_eq({tag, ".active"}, {7'b0, bus.active}, {7'b0, act});
    check_eq({tag, ".busy"},   {7'b0, bus.busy},   {7'b0, bsy});
    check_eq({tag, ".step"},   {7'b0, bus.step},   {7'b0, stp});
    check_eq({tag, ".done"},   {7'b0, bus.done},   {7'b0, dn});
  endtask

  // stop_m: edge number (1 = start edge) at which stop is seen; 0 = never.
  task automatic run_scan(input string tag, input logic [3:0] mask, input int dw,
                          input bit c, input int stop_m, input bit noise);
    int lines[$];
    int k, d, e_last, idx;
    logic [1:0] ea, prev_a;
    logic eact, ebsy, estp, edn;
    for (int i = 0; i < 4; i++) if (mask[i]) lines.push_back(i);
    k = lines.size();
    d = (dw == 0) ? 1 : dw;
    e_last = (stop_m > 0) ? stop_m : k * d + 2;
    prev_a = last_addr;
    for (int n = 1; n <= e_last; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start   = 1'b1;
        bus.stop    = 1'b0;
        bus.line_en = mask;
        bus.dwell   = dw[7:0];
        bus.cont    = c;
      end else begin
        bus.stop = (n == stop_m);
        if (noise) begin
          bus.start   = 1'($urandom_range(0, 1));
          bus.line_en = 4'($urandom);
          bus.dwell   = 8'($urandom);
          bus.cont    = 1'($urandom_range(0, 1));
        end else begin
          bus.start = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      idx = n - 1;
      if (n == stop_m) begin
        ea = prev_a; eact = 1'b0; ebsy = 1'b0; estp = 1'b0; edn = 1'b0;
      end else if (c || idx < k * d) begin
        ea   = 2'(lines[(idx / d) % k]);
        eact = 1'b1; ebsy = 1'b1; edn = 1'b0;
        estp = (idx > 0) && (idx % d == 0);
      end else if (idx == k * d) begin
        ea = 2'(lines[k-1]); eact = 1'b0; ebsy = 1'b1; estp = 1'b0; edn = 1'b1;
      end else begin
        ea = 2'(lines[k-1]); eact = 1'b0; ebsy = 1'b0; estp = 1'b0; edn = 1'b0;
      end
      check_outs(tag, ea, eact, ebsy, estp, edn);
      prev_a = ea;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    last_addr = prev_a;
    @(posedge clk);
    #1;
    check_outs({tag, ".idle"}, last_addr, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_attempt(input string tag, input logic [3:0] mask, input logic st,
                              input logic sp);
    @(negedge clk);
    bus.start   = st;
    bus.stop    = sp;
    bus.line_en = mask;
    bus.dwell   = 8'($urandom_range(0, 5));
    bus.cont    = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs(tag, last_addr, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    logic [3:0] m;
    int dw, k, sm;
    bit c;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.cont    = 1'b0;
    bus.dwell   = '0;
    bus.line_en = '0;
    #1;
    check_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-scan: line 2 with counter at 3.
    @(negedge clk);
    bus.start = 1'b1; bus.line_en = 4'b0100; bus.dwell = 8'd5; bus.cont = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    check_outs("pre_rst", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    last_addr = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_outs("post_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    run_scan("sweep1111", 4'b1111, 2, 1'b0, 0, 1'b0);
    run_scan("cont1010", 4'b1010, 0, 1'b1, 9, 1'b0);
    idle_attempt("empty_mask", 4'b0000, 1'b1, 1'b0);
    idle_attempt("start_stop", 4'b1111, 1'b1, 1'b1);
    run_scan("single_cont", 4'b0100, 3, 1'b1, 11, 1'b1);
    run_scan("start_ignored", 4'b0110, 2, 1'b0, 0, 1'b1);
    run_scan("fresh", 4'b1001, 1, 1'b0, 0, 1'b0);
    run_scan("stop_last", 4'b0011, 2, 1'b0, 5, 1'b0);

    for (int r = 0; r < 30; r++) begin
      m  = 4'($urandom_range(1, 15));
      dw = $urandom_range(0, 4);
      c  = 1'($urandom_range(0, 1));
      k  = $countones(m);
      if (c) sm = $urandom_range(2, 20);
      else if ($urandom_range(0, 2) == 0) sm = $urandom_range(2, k * ((dw == 0) ? 1 : dw) + 1);
      else sm = 0;
      run_scan("rand", m, dw, c, sm, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
